// File: rtl/tx_arbiter_if.sv
// Bundle between message requesters / byte serializer and the tx_arbiter.
// Handshake: a requester holds req_valid[i] with stable req_d/req_bytecount slices until it
// sees the one-cycle req_ack[i] pulse; ser_begin is a one-cycle load strobe qualified by ser_d/ser_bytecount.
interface tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 256,
  parameter int CW   = 6
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_d;
  logic [NREQ*CW-1:0] req_bytecount;
  logic [NREQ-1:0]    req_ack;
  logic [DW-1:0]      ser_d;
  logic [CW-1:0]      ser_bytecount;
  logic               ser_begin;
  logic               ser_empty;
  logic               busy;
  logic [2:0]         grant_id;
  logic               timeout_err;

  modport master (
    output req_valid, req_d, req_bytecount, ser_empty,
    input  req_ack, ser_d, ser_bytecount, ser_begin, busy, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_d, req_bytecount, ser_empty,
    output req_ack, ser_d, ser_bytecount, ser_begin, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that grants one framed message at a time to the UART byte serializer
// and sequences LOAD -> START -> DRAIN before returning to IDLE.
module tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 256,
  parameter int CW   = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  tx_arbiter_if.slave bus,
  output logic [1:0]  dbg_state_o,
  output logic [2:0]  dbg_rr_ptr_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, START = 2'd2, DRAIN = 2'd3} state_e;

  localparam logic [CW-1:0] MAX_BYTES = CW'(DW / 8);

  state_e          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   ser_d_q, ser_d_d;
  logic [CW-1:0]   bc_q, bc_d;
  logic            ser_begin_q, ser_begin_d;
  logic            tmo_q, tmo_d;
  logic [3:0]      start_cnt_q, start_cnt_d;

  logic [NREQ-1:0] eligible;
  logic            pick_found;
  logic [2:0]      pick_idx;
  logic [DW-1:0]   pick_data;
  logic [CW-1:0]   pick_len;

  // Requesters acked last cycle may still show valid; mask them so a dropped
  // zero-length request is not granted a second time.
  always_comb begin
    eligible   = bus.req_valid & ~ack_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && eligible[(int'(rr_ptr_q) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = 3'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
    pick_data = bus.req_d[int'(pick_idx)*DW +: DW];
    pick_len  = bus.req_bytecount[int'(pick_idx)*CW +: CW];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    ack_d       = '0;
    ser_d_d     = ser_d_q;
    bc_d        = bc_q;
    ser_begin_d = 1'b0;
    tmo_d       = tmo_q;
    start_cnt_d = start_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          ack_d    = NREQ'(1) << pick_idx;
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == 3'(NREQ - 1)) ? 3'd0 : pick_idx + 3'd1;
          ser_d_d  = pick_data;
          bc_d     = (pick_len > MAX_BYTES) ? MAX_BYTES : pick_len;
          if (pick_len != '0) state_d = LOAD;
        end
      end
      LOAD: begin
        ser_begin_d = 1'b1;
        start_cnt_d = '0;
        state_d     = START;
      end
      START: begin
        // Sixteen START cycles with ser_empty still high means the serializer never took the load.
        if (!bus.ser_empty) begin
          state_d = DRAIN;
        end else if (start_cnt_q == 4'd15) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        if (bus.ser_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      ser_d_q     <= '0;
      bc_q        <= '0;
      ser_begin_q <= 1'b0;
      tmo_q       <= 1'b0;
      start_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      ser_d_q     <= ser_d_d;
      bc_q        <= bc_d;
      ser_begin_q <= ser_begin_d;
      tmo_q       <= tmo_d;
      start_cnt_q <= start_cnt_d;
    end
  end

  assign bus.req_ack       = ack_q;
  assign bus.ser_d         = ser_d_q;
  assign bus.ser_bytecount = bc_q;
  assign bus.ser_begin     = ser_begin_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.grant_id      = grant_q;
  assign bus.timeout_err   = tmo_q;
  assign dbg_state_o       = state_q;
  assign dbg_rr_ptr_o      = rr_ptr_q;

endmodule
